// File: rtl/dptr_bank.sv
// Purpose: bank of 8051-style 16-bit data pointers with DPS select/auto-modify control.
// Latency: register updates land on the clock edge; data_h/data_l/sfr_rd_data are combinational.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module dptr_bank #(
    parameter int         NUM_PTRS = 2,
    parameter logic [7:0] SFR_DPL  = 8'h82,
    parameter logic [7:0] SFR_DPH  = 8'h83,
    parameter logic [7:0] SFR_DPS  = 8'h86
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_en,
    input  logic        write_bit_en,
    input  logic [7:0]  addr,
    input  logic [7:0]  data_in,
    input  logic        load16_en,
    input  logic [15:0] load16_data,
    input  logic        inc_en,
    input  logic        movx_done,
    output logic [7:0]  data_h,
    output logic [7:0]  data_l,
    output logic [7:0]  dps_out,
    output logic [7:0]  sfr_rd_data
);

    localparam int              SEL_W   = (NUM_PTRS <= 2) ? 1 : $clog2(NUM_PTRS);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_PTRS - 1);
    localparam logic [7:0]      NPTR_8  = 8'(NUM_PTRS);

    logic [15:0]      ptr_q [NUM_PTRS];
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             aid_q, aid_d;
    logic             aie_q, aie_d;
    logic             tsl_q, tsl_d;

    logic             byte_wr;
    logic             wr_dpl, wr_dph, wr_dps;
    logic [15:0]      cur_ptr;
    logic [15:0]      ptr_d;
    logic             ptr_we;
    logic             auto_mod;
    logic [7:0]       sel_wr_ext;

    // Bit-addressed writes share the strobe but must never touch the byte registers.
    assign byte_wr = write_en & ~write_bit_en;
    assign wr_dpl  = byte_wr && (addr == SFR_DPL);
    assign wr_dph  = byte_wr && (addr == SFR_DPH);
    assign wr_dps  = byte_wr && (addr == SFR_DPS);

    // Select the active pointer by SEL.
    always_comb begin
        cur_ptr = ptr_q[0];
        for (int i = 0; i < NUM_PTRS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_ptr = ptr_q[i];
            end
        end
    end

    assign data_h = cur_ptr[15:8];
    assign data_l = cur_ptr[7:0];

    // Prioritised next value of the active pointer: byte write > load16 > inc > auto-modify.
    always_comb begin
        ptr_d    = cur_ptr;
        ptr_we   = 1'b0;
        auto_mod = 1'b0;
        if (wr_dpl) begin
            ptr_d  = {cur_ptr[15:8], data_in};
            ptr_we = 1'b1;
        end else if (wr_dph) begin
            ptr_d  = {data_in, cur_ptr[7:0]};
            ptr_we = 1'b1;
        end else if (load16_en) begin
            ptr_d  = load16_data;
            ptr_we = 1'b1;
        end else if (inc_en) begin
            ptr_d  = cur_ptr + 16'd1;
            ptr_we = 1'b1;
        end else if (movx_done && aie_q) begin
            ptr_d    = aid_q ? (cur_ptr - 16'd1) : (cur_ptr + 16'd1);
            ptr_we   = 1'b1;
            auto_mod = 1'b1;
        end
    end

    // Next DPS: an explicit write beats the TSL advance; out-of-range SEL clamps to the last pointer.
    always_comb begin
        sel_wr_ext = {{(8-SEL_W){1'b0}}, data_in[SEL_W-1:0]};
        sel_d      = sel_q;
        aid_d      = aid_q;
        aie_d      = aie_q;
        tsl_d      = tsl_q;
        if (wr_dps) begin
            sel_d = (sel_wr_ext >= NPTR_8) ? SEL_MAX : data_in[SEL_W-1:0];
            aid_d = data_in[4];
            aie_d = data_in[5];
            tsl_d = data_in[6];
        end else if (auto_mod && tsl_q) begin
            sel_d = (sel_q == SEL_MAX) ? '0 : (sel_q + SEL_W'(1));
        end
    end

    // Only the pointer selected before this edge may change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PTRS; i++) begin
                ptr_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_PTRS; i++) begin
                if (ptr_we && (sel_q == SEL_W'(i))) begin
                    ptr_q[i] <= ptr_d;
                end
            end
        end
    end

    // DPS control register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_q <= '0;
            aid_q <= 1'b0;
            aie_q <= 1'b0;
            tsl_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            aid_q <= aid_d;
            aie_q <= aie_d;
            tsl_q <= tsl_d;
        end
    end

    // Assemble DPS image; unimplemented bits read as zero.
    always_comb begin
        dps_out              = 8'h00;
        dps_out[SEL_W-1:0]   = sel_q;
        dps_out[4]           = aid_q;
        dps_out[5]           = aie_q;
        dps_out[6]           = tsl_q;
    end

    // SFR read mux.
    always_comb begin
        sfr_rd_data = 8'h00;
        if (addr == SFR_DPL) begin
            sfr_rd_data = data_l;
        end else if (addr == SFR_DPH) begin
            sfr_rd_data = data_h;
        end else if (addr == SFR_DPS) begin
            sfr_rd_data = dps_out;
        end
    end

endmodule

// File: tb/tb_dptr_bank.sv
// Purpose: directed bench for dptr_bank with a two-pointer and a three-pointer instance on shared stimulus.
// Latency: checks every falling edge against a reference model, plus literal checks 1 time unit after edges.
// Backpressure: not applicable; stimulus is fixed-cycle.
module tb_dptr_bank;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        write_en = 1'b0;
    logic        write_bit_en = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  data_in = 8'h00;
    logic        load16_en = 1'b0;
    logic [15:0] load16_data = 16'h0000;
    logic        inc_en = 1'b0;
    logic        movx_done = 1'b0;

    logic [7:0]  dh [2];
    logic [7:0]  dl [2];
    logic [7:0]  dps [2];
    logic [7:0]  rd [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    always #5 clock = ~clock;

    dptr_bank #(.NUM_PTRS(2)) u_dut2 (
        .clock(clock), .reset(reset), .write_en(write_en), .write_bit_en(write_bit_en),
        .addr(addr), .data_in(data_in), .load16_en(load16_en), .load16_data(load16_data),
        .inc_en(inc_en), .movx_done(movx_done),
        .data_h(dh[0]), .data_l(dl[0]), .dps_out(dps[0]), .sfr_rd_data(rd[0])
    );

    dptr_bank #(.NUM_PTRS(3)) u_dut3 (
        .clock(clock), .reset(reset), .write_en(write_en), .write_bit_en(write_bit_en),
        .addr(addr), .data_in(data_in), .load16_en(load16_en), .load16_data(load16_data),
        .inc_en(inc_en), .movx_done(movx_done),
        .data_h(dh[1]), .data_l(dl[1]), .dps_out(dps[1]), .sfr_rd_data(rd[1])
    );

    // ---------------- reference model (integer arithmetic on the architectural state) ----------------
    int NP [2] = '{2, 3};
    int m_ptr [2][8];
    int m_sel [2];
    bit m_aid [2];
    bit m_aie [2];
    bit m_tsl [2];

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) m_ptr[k][j] = 0;
            m_sel[k] = 0;
            m_aid[k] = 0;
            m_aie[k] = 0;
            m_tsl[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int  n, s, p, ns, w, span;
        bit  bwr, adv;
        n   = NP[k];
        s   = m_sel[k];
        p   = m_ptr[k][s];
        ns  = s;
        adv = 0;
        bwr = write_en && !write_bit_en;
        if (bwr && addr == 8'h82)      p = (p / 256) * 256 + int'(data_in);
        else if (bwr && addr == 8'h83) p = int'(data_in) * 256 + (p % 256);
        else if (load16_en)            p = int'(load16_data);
        else if (inc_en)               p = (p + 1) % 65536;
        else if (movx_done && m_aie[k]) begin
            p   = m_aid[k] ? (p + 65535) % 65536 : (p + 1) % 65536;
            adv = m_tsl[k];
        end
        m_ptr[k][s] = p;
        if (adv) ns = (s + 1) % n;
        if (bwr && addr == 8'h86) begin
            span     = (n <= 2) ? 2 : (n <= 4) ? 4 : 8;
            w        = int'(data_in) % span;
            ns       = (w >= n) ? n - 1 : w;
            m_aid[k] = data_in[4];
            m_aie[k] = data_in[5];
            m_tsl[k] = data_in[6];
        end
        m_sel[k] = ns;
    endtask

    function automatic int e_ptr(input int k);
        return m_ptr[k][m_sel[k]];
    endfunction

    function automatic int e_dps(input int k);
        return m_sel[k] + (m_aid[k] ? 16 : 0) + (m_aie[k] ? 32 : 0) + (m_tsl[k] ? 64 : 0);
    endfunction

    function automatic int e_rd(input int k);
        if (addr == 8'h82) return e_ptr(k) % 256;
        if (addr == 8'h83) return e_ptr(k) / 256;
        if (addr == 8'h86) return e_dps(k);
        return 0;
    endfunction

    initial model_clear();

    always @(posedge clock or negedge reset) begin
        if (!reset) model_clear();
        else for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc_h[%0d]", k), int'(dh[k]), e_ptr(k) / 256);
                chk($sformatf("cyc_l[%0d]", k), int'(dl[k]), e_ptr(k) % 256);
                chk($sformatf("cyc_dps[%0d]", k), int'(dps[k]), e_dps(k));
                chk($sformatf("cyc_rd[%0d]", k), int'(rd[k]), e_rd(k));
            end
        end
    end

    // Literal expectation for instance k: checks the DUT and pins the model.
    task automatic lit(input int k, input string nm, input int hl, input int dps_exp);
        chk({nm, "_dut_hl"}, int'({dh[k], dl[k]}), hl);
        chk({nm, "_dut_dps"}, int'(dps[k]), dps_exp);
        chk({nm, "_model_hl"}, e_ptr(k), hl);
    endtask

    task automatic lit2(input string nm, input int hl, input int dps_exp);
        lit(0, {nm, "_n2"}, hl, dps_exp);
        lit(1, {nm, "_n3"}, hl, dps_exp);
    endtask

    // ---------------- stimulus ----------------
    task automatic clr();
        write_en = 0; write_bit_en = 0; load16_en = 0; inc_en = 0; movx_done = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        clr();
    endtask

    task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
        clr(); write_en = 1; addr = a; data_in = d; step();
    endtask

    task automatic load(input logic [15:0] v);
        clr(); load16_en = 1; load16_data = v; step();
    endtask

    task automatic inc();
        clr(); inc_en = 1; step();
    endtask

    task automatic movx();
        clr(); movx_done = 1; step();
    endtask

    task automatic peek_all();
        logic [7:0] al [5] = '{8'h82, 8'h83, 8'h86, 8'h81, 8'h00};
        for (int i = 0; i < 5; i++) begin
            clr(); addr = al[i]; step();
        end
    endtask

    initial begin
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_h[%0d]", k), int'(dh[k]), 0);
            chk($sformatf("reset_l[%0d]", k), int'(dl[k]), 0);
            chk($sformatf("reset_dps[%0d]", k), int'(dps[k]), 0);
        end
        @(posedge clock); #2;
        reset = 1;
        started = 1;
        step();

        // Byte writes then increment
        sfr_wr(8'h82, 8'h34);
        sfr_wr(8'h83, 8'h12);
        inc();
        lit2("dpl_dph_inc", 16'h1235, 8'h00);
        peek_all();

        // Increment wrap and decrement wrap
        load(16'hFFFF);
        inc();
        lit2("inc_wrap", 16'h0000, 8'h00);
        sfr_wr(8'h86, 8'h30);
        movx();
        lit2("dec_wrap", 16'hFFFF, 8'h30);

        // Auto-modify with TSL advance
        sfr_wr(8'h86, 8'h00);
        load(16'h1000);
        sfr_wr(8'h86, 8'h01);
        load(16'h2000);
        sfr_wr(8'h86, 8'h60);
        movx();
        lit2("tsl_adv", 16'h2000, 8'h61);
        peek_all();
        sfr_wr(8'h86, 8'h00);
        lit2("ptr0_after_mod", 16'h1001, 8'h00);

        // Priority and ignored writes
        load(16'h00FF);
        clr(); write_en = 1; addr = 8'h82; data_in = 8'hAA; inc_en = 1; step();
        lit2("wr_beats_inc", 16'h00AA, 8'h00);
        clr(); write_en = 1; write_bit_en = 1; addr = 8'h83; data_in = 8'h55; step();
        lit2("bit_wr_ignored", 16'h00AA, 8'h00);
        sfr_wr(8'h81, 8'h77);
        lit2("other_sfr", 16'h00AA, 8'h00);
        clr(); load16_en = 1; load16_data = 16'h1234; inc_en = 1; step();
        lit2("load_beats_inc", 16'h1234, 8'h00);
        sfr_wr(8'h86, 8'h20);
        clr(); inc_en = 1; movx_done = 1; step();
        lit2("inc_beats_auto", 16'h1235, 8'h20);

        // DPS write coinciding with a TSL advance
        sfr_wr(8'h86, 8'h60);
        clr(); movx_done = 1; write_en = 1; addr = 8'h86; data_in = 8'h22; step();
        lit(0, "dps_beats_tsl_n2", 16'h1236, 8'h20);
        lit(1, "dps_beats_tsl_n3", 16'h0000, 8'h22);
        sfr_wr(8'h86, 8'h00);
        lit2("ptr0_after_coincide", 16'h1236, 8'h00);

        // SEL clamping and unwritable bits
        sfr_wr(8'h86, 8'h03);
        lit(0, "sel3_n2", 16'h2000, 8'h01);
        lit(1, "sel3_n3", 16'h0000, 8'h02);
        sfr_wr(8'h86, 8'hFF);
        lit(0, "dpsff_n2", 16'h2000, 8'h71);
        lit(1, "dpsff_n3", 16'h0000, 8'h72);
        peek_all();
        sfr_wr(8'h86, 8'h00);

        // Asynchronous reset mid-operation, then normal action on first edge after release
        clr(); load16_en = 1; load16_data = 16'hABCD;
        @(posedge clock); #3;
        reset = 0;
        #1;
        lit2("async_reset", 16'h0000, 8'h00);
        @(posedge clock); #1;
        lit2("held_reset", 16'h0000, 8'h00);
        #1 reset = 1;
        @(posedge clock); #1;
        lit2("first_edge_after_reset", 16'hABCD, 8'h00);
        clr();
        peek_all();

        started = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
